fetch_unit: RTL and testbench

//  Program counter and fetch sequencer directly upstream of the 128x8 instruction ROM.
//  - Drives the ROM address.
//  - Re-aligns the ROM's 1-cycle registered read data with a valid flag and the fetch PC.
//  - Applies decoder stalls and branch redirects, squashing the wrong-path fetch.
//  - Presents {instr, instr_pc, instr_valid} to the decode stage.

---
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer feeding a 1-cycle registered instruction ROM.
// Re-aligns ROM data with its fetch PC, applies decode stalls and squashes wrong-path fetches on branches.
module fetch_unit #(
    parameter int AW        = 7,
    parameter int IW        = 8,
    parameter int RESET_VEC = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_en,
    input  logic          branch_rel,
    input  logic [AW-1:0] branch_target,
    output logic [AW-1:0] rom_addr,
    output logic          rom_re,
    input  logic [IW-1:0] rom_q,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid
);

    typedef enum logic [1:0] {BOOT, RUN, STALL, REDIR} state_t;

    localparam logic [AW-1:0] RESET_PC = AW'(RESET_VEC);

    state_t        r_state;
    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] r_instr_pc;

    logic          w_active;
    logic          w_hold;
    logic [AW-1:0] w_target;

    assign w_active = (r_state == RUN) || (r_state == STALL);
    assign w_hold   = w_active && stall;

    // Offset and absolute target share one AW-bit field, so the plain add is the mod-2^AW signed add.
    assign w_target = branch_rel ? (r_instr_pc + AW'(1) + branch_target) : branch_target;

    // A stalling cycle re-reads the held address so rom_q still carries the held instruction
    // on the following cycle; every other cycle fetches ahead from fetch_pc.
    assign rom_addr    = w_hold ? r_instr_pc : r_fetch_pc;
    assign rom_re      = reset;
    assign instr       = rom_q;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = reset && w_active;

    // NOTE: state registers use non-blocking assignments so every branch of the case
    // samples the pre-edge values of r_fetch_pc and r_instr_pc.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_instr_pc <= RESET_PC;
        end else begin
            case (r_state)
                BOOT, REDIR: begin
                    r_instr_pc <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + AW'(1);
                    r_state    <= RUN;
                end
                RUN, STALL: begin
                    if (stall) begin
                        r_state <= STALL;
                    end else if (branch_en) begin
                        r_fetch_pc <= w_target;
                        r_state    <= REDIR;
                    end else begin
                        r_instr_pc <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + AW'(1);
                        r_state    <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 128x8 registered ROM.
// Expected PCs and instruction bytes are hand-sequenced; ROM contents come from rom_val().
module tb_fetch_unit;

    localparam int AW = 7;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          branch_en;
    logic          branch_rel;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] rom_addr;
    logic          rom_re;
    logic [IW-1:0] rom_q;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    logic [IW-1:0] rom_mem [128];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.AW(AW), .IW(IW), .RESET_VEC(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .rom_addr      (rom_addr),
        .rom_re        (rom_re),
        .rom_q         (rom_q),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_re) rom_q <= rom_mem[rom_addr];
    end

    function automatic logic [IW-1:0] rom_val(input int pc);
        return IW'(pc * 37 + 11);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input string tag, input int pc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".pc"},    32'(instr_pc),    32'(pc));
        check({tag, ".instr"}, 32'(instr),       32'(rom_val(pc)));
    endtask

    task automatic branch_abs(input int tgt);
        branch_en     = 1'b1;
        branch_rel    = 1'b0;
        branch_target = AW'(tgt);
    endtask

    task automatic branch_off(input int off);
        branch_en     = 1'b1;
        branch_rel    = 1'b1;
        branch_target = AW'(off);
    endtask

    // Take the branch set up by the caller: one squashed cycle, then the target.
    task automatic take_branch(input string tag, input int tgt);
        tick();
        check({tag, ".bubble"}, 32'(instr_valid), 32'd0);
        branch_en = 1'b0;
        tick();
        expect_instr({tag, ".tgt"}, tgt);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = rom_val(i);
        rom_q         = '0;
        reset         = 1'b0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        branch_rel    = 1'b0;
        branch_target = '0;

        // Reset state
        tick();
        tick();
        check("rst.valid",  32'(instr_valid), 32'd0);
        check("rst.rom_re", 32'(rom_re),      32'd0);
        check("rst.pc",     32'(instr_pc),    32'd0);
        check("rst.addr",   32'(rom_addr),    32'd0);

        // Release: BOOT cycle, then first valid instruction one cycle later
        reset = 1'b1;
        #1;
        check("boot.valid",  32'(instr_valid), 32'd0);
        check("boot.rom_re", 32'(rom_re),      32'd1);
        tick();
        expect_instr("seq0", 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            expect_instr($sformatf("seq%0d", k), k);
        end

        // Stall for three cycles at pc 5
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_instr($sformatf("stall%0d", k), 5);
        end
        stall = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            tick();
            expect_instr($sformatf("post_stall%0d", k), k);
        end

        // Absolute branch to 0x40 at pc 10
        branch_abs(8'h40);
        take_branch("abs40", 8'h40);
        tick();
        expect_instr("abs40.next", 8'h41);

        // Get to pc 1, then relative -2 lands on 0, and again from 0 wraps to 127
        branch_abs(1);
        take_branch("to1", 1);
        branch_off(8'h7E);
        take_branch("rel_m2_a", 0);
        branch_off(8'h7E);
        take_branch("rel_m2_b", 127);
        tick();
        expect_instr("wrap127_0", 0);

        // Sequential wrap 126,127,0,1
        branch_abs(126);
        take_branch("to126", 126);
        tick();
        expect_instr("wrap.127", 127);
        tick();
        expect_instr("wrap.0", 0);
        tick();
        expect_instr("wrap.1", 1);

        // Branch to self: relative -1 repeats pc 1 with one bubble per loop
        branch_off(8'h7F);
        take_branch("self_a", 1);
        branch_off(8'h7F);
        take_branch("self_b", 1);

        // Reset while stalled: valid drops in the reset cycle and the BOOT cycle
        stall = 1'b1;
        tick();
        expect_instr("pre_rst_stall", 1);
        reset = 1'b0;
        #1;
        check("rst_stall.valid0", 32'(instr_valid), 32'd0);
        tick();
        stall = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_stall.valid1", 32'(instr_valid), 32'd0);
        tick();
        expect_instr("rst_stall.restart", 0);

        // Stall and branch together at pc 20: no redirect until stall drops
        branch_abs(20);
        take_branch("to20", 20);
        stall = 1'b1;
        branch_abs(8'h30);
        tick();
        expect_instr("sb.hold0", 20);
        tick();
        expect_instr("sb.hold1", 20);
        stall = 1'b0;
        tick();
        check("sb.bubble", 32'(instr_valid), 32'd0);
        check("sb.addr",   32'(rom_addr),    32'h30);

        // Reset asserted in REDIR
        branch_en = 1'b0;
        reset     = 1'b0;
        #1;
        check("redir_rst.valid0", 32'(instr_valid), 32'd0);
        check("redir_rst.rom_re", 32'(rom_re),      32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("redir_rst.valid1", 32'(instr_valid), 32'd0);
        check("redir_rst.addr",   32'(rom_addr),    32'd0);
        tick();
        expect_instr("redir_rst.restart0", 0);
        tick();
        expect_instr("redir_rst.restart1", 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
